resource_arbiter: RTL and testbench

Shared-resource side of the pipeline arbiter handshake. Up to NUM_REQ pipelines raise a request and hold their data; this block grants one per cycle in round-robin order and forwards the granted beat to a fixed-latency shared resource. It tracks which requester owns each in-flight beat and routes the resource result back to the owner with a one-hot response valid. A requester whose grant is low treats that grant-low as its stall.

---
 rtl/resource_arbiter.sv | 151 +++++++++++++++
 tb/tb_resource_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin grant of NUM_REQ requesters onto one
// fixed-latency shared resource, with owner tags travelling alongside each
// beat so the returning result is steered back as a one-hot response valid.
// Optional build macro RESOURCE_ARB_CHECK_EN enables the sticky err flag for
// unexpected or missing resource results; without it err is tied low.
module resource_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int RES_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         res_in,
    output logic                      res_in_valid,
    input  logic [DATA_W-1:0]         res_out,
    input  logic                      res_out_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr_p0;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   xfer_idx;
    logic               xfer;
    logic [DATA_W-1:0]  xfer_data;
    logic [NUM_REQ-1:0] xfer_tag;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] tag_p [RES_LAT+1];
    logic [NUM_REQ-1:0] tag_out;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    // Detect the transfer: the granted requester is still requesting.
    always_comb begin
        xfer      = 1'b0;
        xfer_idx  = '0;
        xfer_data = '0;
        xfer_tag  = grant & req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req[i]) begin
                xfer      = 1'b1;
                xfer_idx  = IDX_W'(i);
                xfer_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search from the post-update pointer; wrap is done by
    // explicit subtraction so non-power-of-2 NUM_REQ works. Scanning from the
    // far end lets the nearest requester overwrite the result last.
    always_comb begin
        ptr_nxt   = xfer ? xfer_idx : ptr_p0;
        grant_nxt = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(ptr_nxt) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                grant_nxt           = '0;
                grant_nxt[cand_idx] = 1'b1;
            end
        end
    end

    // Stage 0: arbitration state and the beat register feeding the resource.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_p0       <= IDX_W'(NUM_REQ - 1);
            grant        <= '0;
            res_in       <= '0;
            res_in_valid <= 1'b0;
        end else if (flush) begin
            grant        <= '0;
            res_in_valid <= 1'b0;
        end else begin
            ptr_p0       <= ptr_nxt;
            grant        <= grant_nxt;
            res_in_valid <= xfer;
            if (xfer) begin
                res_in <= xfer_data;
            end
        end
    end

    // Owner tags: stage 0 is aligned with res_in, stage RES_LAT with res_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j <= RES_LAT; j++) begin
                tag_p[j] <= '0;
            end
        end else if (flush) begin
            for (int j = 0; j <= RES_LAT; j++) begin
                tag_p[j] <= '0;
            end
        end else begin
            tag_p[0] <= xfer ? xfer_tag : '0;
            for (int j = 1; j <= RES_LAT; j++) begin
                tag_p[j] <= tag_p[j-1];
            end
        end
    end

    assign tag_out = tag_p[RES_LAT];

    // Response stage: capture the result and steer it to its owner; a zero
    // tag (flushed beat) yields no response valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data  <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= '0;
            if (res_out_valid) begin
                rsp_data <= res_out;
                if (!flush) begin
                    rsp_valid <= tag_out;
                end
            end
        end
    end

`ifdef RESOURCE_ARB_CHECK_EN
    logic err_p0;

    // Sticky error when the resource result and the expected tag disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_p0 <= 1'b0;
        end else if ((res_out_valid && (tag_out == '0)) ||
                     (!res_out_valid && (tag_out != '0))) begin
            err_p0 <= 1'b1;
        end
    end

    assign err = err_p0;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_resource_arbiter.sv
// Bench for resource_arbiter: grant table, hand-written corner sequences and
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_resource_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           flush;
    logic [N-1:0]   grant;
    logic [W-1:0]   res_in;
    logic           res_in_valid;
    logic [W-1:0]   res_out;
    logic           res_out_valid;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_valid;
    logic           err;

    resource_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .flush(flush), .grant(grant), .res_in(res_in),
        .res_in_valid(res_in_valid), .res_out(res_out),
        .res_out_valid(res_out_valid), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: expected grant, round-robin pointer, the beat
    // last sent to the resource, and a list of outstanding responses keyed by
    // the edge at which each should appear.
    typedef struct {
        int           due;
        logic [N-1:0] owner;
        logic [W-1:0] data;
    } pend_t;
    typedef struct {
        logic         v;
        logic [W-1:0] d;
    } beat_t;

    logic [N-1:0] m_grant;
    int           m_ptr;
    logic         m_riv;
    logic [W-1:0] m_res_in;
    logic         m_err;
    pend_t        pend[$];
    beat_t        rq[$];
    logic         inj;
    logic         check_en;

    task automatic model_reset();
        beat_t b;
        m_grant  = '0;
        m_ptr    = N - 1;
        m_riv    = 1'b0;
        m_res_in = '0;
        m_err    = 1'b0;
        pend.delete();
        rq.delete();
        b.v = 1'b0;
        b.d = '0;
        for (int i = 0; i < LAT; i++) rq.push_back(b);
        res_out_valid = 1'b0;
        res_out       = '0;
    endtask

    // One clock: update the model from the inputs of the cycle, take the
    // edge, play the resource (result = beat + 1 after LAT cycles), compare.
    task automatic step();
        int           xi;
        logic [N-1:0] g_n;
        logic         fl;
        logic         due_now;
        logic [N-1:0] exp_v;
        logic [W-1:0] exp_d;
        beat_t        b;
        pend_t        p;
        fl = flush;
        due_now = (pend.size() > 0) && (pend[0].due == cyc + 1);
        if (check_en && (res_out_valid != due_now)) m_err = 1'b1;
        xi = -1;
        for (int i = 0; i < N; i++) if (m_grant[i] && req[i]) xi = i;
        if (fl) begin
            m_riv   = 1'b0;
            m_grant = '0;
            while (pend.size() > 0 && pend[pend.size()-1].due >= cyc + 1) void'(pend.pop_back());
        end else begin
            if (xi >= 0) begin
                m_riv    = 1'b1;
                m_res_in = req_data[xi*W +: W];
                m_ptr    = xi;
                p.due    = cyc + 1 + LAT + 1;
                p.owner  = '0;
                p.owner[xi] = 1'b1;
                p.data   = req_data[xi*W +: W] + 1;
                pend.push_back(p);
            end else begin
                m_riv = 1'b0;
            end
            g_n = '0;
            for (int k = 1; k <= N; k++) begin
                if (g_n == '0 && req[(m_ptr + k) % N]) g_n[(m_ptr + k) % N] = 1'b1;
            end
            m_grant = g_n;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl) for (int i = 0; i < rq.size(); i++) rq[i].v = 1'b0;
        b.v = res_in_valid;
        b.d = res_in + 1;
        rq.push_back(b);
        b = rq.pop_front();
        res_out_valid = b.v | inj;
        res_out       = b.v ? b.d : $urandom;
        exp_v = '0;
        exp_d = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            exp_v = p.owner;
            exp_d = p.data;
        end
        check("grant", grant, m_grant);
        check("res_in_valid", res_in_valid, m_riv);
        check("res_in", res_in, m_res_in);
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v != '0) check("rsp_data", rsp_data, exp_d);
        check("err", err, m_err);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        req   = '0;
        flush = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         flush;
        logic [N-1:0] exp_grant;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [N-1:0] r;
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[10] = '{4'b0010, 1'b0, 4'b0010};
        tbl[11] = '{4'b0010, 1'b0, 4'b0010};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000};
`ifdef RESOURCE_ARB_CHECK_EN
        check_en = 1'b1;
`else
        check_en = 1'b0;
`endif
        inj      = 1'b0;
        req      = '0;
        req_data = '0;
        flush    = 1'b0;
        reset    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_riv", res_in_valid, 0);
        check("rst_res_in", res_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err", err, 0);
        reset = 1'b1;

        // Grant sequence table.
        for (int v = 0; v < 13; v++) begin
            req   = tbl[v].req;
            flush = tbl[v].flush;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            step();
            check("tbl_grant", grant, tbl[v].exp_grant);
        end
        flush = 1'b0;
        req   = '0;
        repeat (6) step();

        // Lone requester: one beat per cycle, response LAT+2 cycles later.
        do_reset();
        req      = 4'b0010;
        req_data = '0;
        req_data[W +: W] = 32'h0000_00A5;
        step();
        check("single_grant", grant, 4'b0010);
        step();
        check("single_riv", res_in_valid, 1);
        check("single_res_in", res_in, 32'hA5);
        repeat (3) step();
        check("single_rsp_v", rsp_valid, 4'b0010);
        check("single_rsp_d", rsp_data, 32'hA6);
        step();
        check("single_rsp_v2", rsp_valid, 4'b0010);
        req = '0;
        repeat (6) step();

        // Flush with two beats in flight.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        repeat (3) step();
        flush = 1'b1;
        step();
        check("flush_grant", grant, 0);
        check("flush_riv", res_in_valid, 0);
        flush = 1'b0;
        step();
        check("flush_resume", grant, 4'b0100);
        check("flush_rsp0", rsp_valid, 0);
        step();
        check("flush_rsp1", rsp_valid, 0);
        req = '0;
        repeat (6) step();

        // Asynchronous reset between edges in the middle of traffic.
        req = 4'b1111;
        repeat (5) step();
        #3 reset = 1'b0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_riv", res_in_valid, 0);
        check("arst_res_in", res_in, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_err", err, 0);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        model_reset();
        step();
        check("arst_first_grant", grant, 4'b0001);
        req = '0;
        repeat (6) step();

        // Stray resource result with nothing in flight.
        do_reset();
        repeat (2) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        step();
        check("err_set", err, check_en);
        repeat (3) step();
        check("err_hold", err, check_en);
        do_reset();
        step();
        check("err_clear", err, 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom_range(0, 15));
            req   = r;
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) if (m_grant[i]) req_data[i*W +: W] = $urandom;
            step();
        end
        flush = 1'b0;
        req   = '0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
